cordic_iterative_engine: RTL and testbench

CORDIC_ITERATIVE_ENGINE -- requirements
Module: cordic_iterative_engine

---
 rtl/cordic_iterative_engine.sv | 227 ++++++++++++++++++++++
 tb/tb_cordic_iterative_engine.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_iterative_engine.sv
// Iterative CORDIC engine: rotation or vectoring, one micro-rotation per clock.
// Optional post-rotation gain compensation stage enabled by defining CORDIC_GAIN_COMP_EN.
module cordic_iterative_engine #(
   parameter int unsigned M           = 6,
   parameter int unsigned N           = 10,
   parameter int unsigned ITERS       = 12,
   parameter int unsigned ITER_LENGTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  mode,
   input  logic signed [M+N-1:0] x_in,
   input  logic signed [M+N-1:0] y_in,
   input  logic signed [M+N-1:0] z_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic signed [M+N-1:0] x_out,
   output logic signed [M+N-1:0] y_out,
   output logic signed [M+N-1:0] z_out,
   output logic                  busy
);

   localparam int unsigned W         = M + N;
   localparam int unsigned W2        = 2 * W;
   localparam int unsigned TAB_DEPTH = 1 << ITER_LENGTH;

`ifdef CORDIC_GAIN_COMP_EN
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_COMP = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam int                     K_GAIN = int'(0.607252935 * (2.0 ** N));
   localparam logic signed [W2-1:0]   K_WIDE = W2'(K_GAIN);
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd3
   } state_t;
`endif

   // atan(2^-i) scaled by 2^N and rounded; small angles kept at 24 fraction bits,
   // larger i use atan(x) ~ x, exact to the rounding for N <= 24.
   function automatic longint unsigned atan_scaled(int unsigned idx);
      longint unsigned t24;
      longint unsigned res;
      case (idx)
         0:       t24 = 64'd13176795;
         1:       t24 = 64'd7778716;
         2:       t24 = 64'd4110060;
         3:       t24 = 64'd2086331;
         4:       t24 = 64'd1047214;
         5:       t24 = 64'd524117;
         6:       t24 = 64'd262123;
         7:       t24 = 64'd131069;
         default: t24 = 64'd0;
      endcase
      if (idx < 8) begin
         if (N < 24) res = (t24 + (64'd1 << (23 - N))) >> (24 - N);
         else        res = t24 << (N - 24);
      end else if (idx <= N) begin
         res = 64'd1 << (N - idx);
      end else begin
         res = 64'd0;
      end
      return res;
   endfunction

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [ITER_LENGTH-1:0]  r_iter;
   logic                    r_mode;
   logic signed [W-1:0]     r_x;
   logic signed [W-1:0]     r_y;
   logic signed [W-1:0]     r_z;
   logic signed [W-1:0]     r_x_out;
   logic signed [W-1:0]     r_y_out;
   logic signed [W-1:0]     r_z_out;
   logic                    r_in_ready;
   logic                    r_out_valid;
   logic                    r_busy;

   logic                    w_accept;
   logic                    w_last_iter;
   logic                    w_in_ready_nxt;
   logic                    w_out_valid_nxt;
   logic                    w_busy_nxt;
   logic                    w_load_out;
   logic                    w_dir_pos;
   logic signed [W-1:0]     w_x_sh;
   logic signed [W-1:0]     w_y_sh;
   logic signed [W-1:0]     w_atan;
   logic signed [W-1:0]     w_x_rot;
   logic signed [W-1:0]     w_y_rot;
   logic signed [W-1:0]     w_z_rot;
   logic signed [W-1:0]     w_x_res;
   logic signed [W-1:0]     w_y_res;
   logic signed [W-1:0]     w_z_res;
   logic signed [W-1:0]     w_atan_tab [TAB_DEPTH];

   for (genvar g = 0; g < TAB_DEPTH; g++) begin : g_atan
      assign w_atan_tab[g] = (g < ITERS) ? W'(atan_scaled(g)) : '0;
   end

   assign w_accept    = in_valid & r_in_ready;
   assign w_last_iter = (r_iter == ITER_LENGTH'(ITERS - 1));

   // One micro-rotation; direction from sign of z (rotation) or y (vectoring)
   always_comb begin : p_micro_rot
      w_x_sh    = r_x >>> r_iter;
      w_y_sh    = r_y >>> r_iter;
      w_atan    = w_atan_tab[r_iter];
      w_dir_pos = r_mode ? r_y[W-1] : ~r_z[W-1];
      if (w_dir_pos) begin
         w_x_rot = r_x - w_y_sh;
         w_y_rot = r_y + w_x_sh;
         w_z_rot = r_z - w_atan;
      end else begin
         w_x_rot = r_x + w_y_sh;
         w_y_rot = r_y - w_x_sh;
         w_z_rot = r_z + w_atan;
      end
   end

`ifdef CORDIC_GAIN_COMP_EN
   assign w_x_res = W'((W2'(r_x) * K_WIDE) >>> N);
   assign w_y_res = W'((W2'(r_y) * K_WIDE) >>> N);
   assign w_z_res = r_z;
`else
   assign w_x_res = w_x_rot;
   assign w_y_res = w_y_rot;
   assign w_z_res = w_z_rot;
`endif

   always_ff @(posedge clk or negedge rst_n) begin : p_state_reg
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin : p_next_state
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = S_RUN;
`ifdef CORDIC_GAIN_COMP_EN
         S_RUN:  if (w_last_iter) w_state_nxt = S_COMP;
         S_COMP: w_state_nxt = S_DONE;
`else
         S_RUN:  if (w_last_iter) w_state_nxt = S_DONE;
`endif
         S_DONE: if (out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Handshake/status flags are registered from the next state so they track r_state exactly
   always_comb begin : p_out_dec
      w_in_ready_nxt  = 1'b0;
      w_out_valid_nxt = 1'b0;
      w_busy_nxt      = 1'b1;
      w_load_out      = 1'b0;
      case (w_state_nxt)
         S_IDLE: begin
            w_in_ready_nxt = 1'b1;
            w_busy_nxt     = 1'b0;
         end
         S_DONE: begin
            w_out_valid_nxt = 1'b1;
            w_load_out      = (r_state != S_DONE);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin : p_datapath
      if (!rst_n) begin
         r_x    <= '0;
         r_y    <= '0;
         r_z    <= '0;
         r_mode <= 1'b0;
         r_iter <= '0;
      end else if (w_accept) begin
         r_x    <= x_in;
         r_y    <= y_in;
         r_z    <= z_in;
         r_mode <= mode;
         r_iter <= '0;
      end else if (r_state == S_RUN) begin
         r_x    <= w_x_rot;
         r_y    <= w_y_rot;
         r_z    <= w_z_rot;
         r_iter <= r_iter + ITER_LENGTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin : p_out_reg
      if (!rst_n) begin
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_x_out     <= '0;
         r_y_out     <= '0;
         r_z_out     <= '0;
      end else begin
         r_in_ready  <= w_in_ready_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_busy      <= w_busy_nxt;
         if (w_load_out) begin
            r_x_out <= w_x_res;
            r_y_out <= w_y_res;
            r_z_out <= w_z_res;
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign x_out     = r_x_out;
   assign y_out     = r_y_out;
   assign z_out     = r_z_out;

endmodule

// File: tb/tb_cordic_iterative_engine.sv
// Scoreboard bench for cordic_iterative_engine: directed vectors, decoupled result monitor.
module tb_cordic_iterative_engine;

   localparam int unsigned M           = 6;
   localparam int unsigned N           = 10;
   localparam int unsigned ITERS       = 12;
   localparam int unsigned ITER_LENGTH = 4;
   localparam int unsigned W           = M + N;
`ifdef CORDIC_GAIN_COMP_EN
   localparam int LAT = ITERS + 2;
`else
   localparam int LAT = ITERS + 1;
`endif

   typedef struct {
      string name;
      logic  m;
      int    x, y, z;
      int    ex, ey, ez;
      int    tx, ty, tz;
   } vec_t;

   typedef struct {
      string name;
      int    ex, ey, ez;
      int    tx, ty, tz;
      int    acc;
   } exp_t;

   logic                clk;
   logic                rst_n;
   logic                in_valid;
   logic                in_ready;
   logic                mode;
   logic signed [W-1:0] x_in, y_in, z_in;
   logic                out_valid;
   logic                out_ready;
   logic signed [W-1:0] x_out, y_out, z_out;
   logic                busy;

   exp_t sb_q[$];
   int   n_checks    = 0;
   int   n_pass      = 0;
   int   cyc         = 0;
   int   hold_req    = 0;
   int   release_cyc = -1;

   cordic_iterative_engine #(
      .M(M), .N(N), .ITERS(ITERS), .ITER_LENGTH(ITER_LENGTH)
   ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
      .x_in(x_in), .y_in(y_in), .z_in(z_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .x_out(x_out), .y_out(y_out), .z_out(z_out),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_int(input string name, input int act, input int expv, input int tol);
      n_checks++;
      if (act >= expv - tol && act <= expv + tol) n_pass++;
      else $display("FAIL %s: got %0d, want %0d +/- %0d (cycle %0d)", name, act, expv, tol, cyc);
   endtask

   task automatic check_result(input exp_t e, input string tag);
      check_int({e.name, tag, "_x"}, int'(x_out), e.ex, e.tx);
      check_int({e.name, tag, "_y"}, int'(y_out), e.ey, e.ty);
      check_int({e.name, tag, "_z"}, int'(z_out), e.ez, e.tz);
   endtask

   // Offer one operand; optionally push its expected result; returns the accept cycle
   task automatic send(input vec_t v, input bit expect_res, output int acc);
      exp_t e;
      int   waited;
      waited = 0;
      acc    = -1;
      @(negedge clk);
      in_valid = 1'b1;
      mode     = v.m;
      x_in     = W'(v.x);
      y_in     = W'(v.y);
      z_in     = W'(v.z);
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         n_checks++;
         $display("FAIL %s_accept_timeout: in_ready=0 after %0d cycles, want 1", v.name, waited);
         in_valid = 1'b0;
      end else begin
         acc = cyc;
         if (expect_res) begin
            e = '{v.name, v.ex, v.ey, v.ez, v.tx, v.ty, v.tz, acc};
            sb_q.push_back(e);
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         mode     = ~v.m;
         x_in     = 16'sh5a5a;
         y_in     = -16'sd3000;
         z_in     = 16'sh7fff;
         @(negedge clk);
         check_int({v.name, "_busy"}, int'(busy), 1, 0);
         check_int({v.name, "_in_ready_run"}, int'(in_ready), 0, 0);
      end
   endtask

   task automatic drain(input string name);
      int w;
      w = 0;
      while ((sb_q.size() != 0 || out_valid) && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (sb_q.size() != 0) begin
         n_checks++;
         $display("FAIL %s_drain_timeout: %0d results pending, want 0", name, sb_q.size());
      end
      repeat (3) @(negedge clk);
   endtask

   // Result monitor: pops the scoreboard whenever a result is presented
   initial begin : p_monitor
      exp_t e;
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_out_valid: got out_valid=1 at cycle %0d, want 0", cyc);
            end else begin
               e = sb_q.pop_front();
               check_int({e.name, "_latency"}, cyc - e.acc, LAT, 0);
               check_result(e, "");
               if (hold_req > 0) begin
                  out_ready = 1'b0;
                  for (int k = 0; k < hold_req; k++) begin
                     @(negedge clk);
                     check_int({e.name, "_hold_valid"}, int'(out_valid), 1, 0);
                     check_int({e.name, "_hold_in_ready"}, int'(in_ready), 0, 0);
                     check_result(e, "_hold");
                  end
                  hold_req    = 0;
                  release_cyc = cyc;
                  out_ready   = 1'b1;
               end
               @(negedge clk);
               check_int({e.name, "_consumed"}, int'(out_valid), 0, 0);
            end
         end
      end
   end

   initial begin : p_stim
      vec_t vt[4];
      int   acc;
      int   acc2;
      int   ov_seen;
`ifdef CORDIC_GAIN_COMP_EN
      vt[0] = '{"rot_pi4",     1'b0,  622,     0,  804,  440,    440,    0, 4, 4, 2};
      vt[1] = '{"vec_q1",      1'b1, 1024,  1024,    0, 1448,      0,  804, 6, 4, 2};
      vt[2] = '{"rot_neg_pi4", 1'b0, 1024,     0, -804,  724,   -724,    0, 4, 4, 2};
      vt[3] = '{"vec_q4",      1'b1, 1024, -1024,    0, 1448,      0, -804, 6, 4, 2};
`else
      vt[0] = '{"rot_pi4",     1'b0,  622,     0,  804,  724,    724,    0, 4, 4, 2};
      vt[1] = '{"vec_q1",      1'b1, 1024,  1024,    0, 2385,      0,  804, 6, 4, 2};
      vt[2] = '{"rot_neg_pi4", 1'b0, 1024,     0, -804, 1192,  -1192,    0, 4, 4, 2};
      vt[3] = '{"vec_q4",      1'b1, 1024, -1024,    0, 2385,      0, -804, 6, 4, 2};
`endif
      rst_n    = 1'b0;
      in_valid = 1'b0;
      mode     = 1'b0;
      x_in     = '0;
      y_in     = '0;
      z_in     = '0;
      repeat (3) @(negedge clk);
      check_int("rst_in_ready", int'(in_ready), 0, 0);
      check_int("rst_busy", int'(busy), 0, 0);
      check_int("rst_out_valid", int'(out_valid), 0, 0);
      check_int("rst_x_out", int'(x_out), 0, 0);
      check_int("rst_y_out", int'(y_out), 0, 0);
      check_int("rst_z_out", int'(z_out), 0, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_int("post_rst_in_ready", int'(in_ready), 1, 0);
      check_int("post_rst_busy", int'(busy), 0, 0);

      for (int i = 0; i < 4; i++) send(vt[i], 1'b1, acc);
      drain("basic");

      // Stall the consumer for five cycles while a second operand waits
      send(vt[0], 1'b1, acc);
      hold_req = 5;
      send(vt[1], 1'b1, acc2);
      check_int("second_accept_after_release", acc2 - release_cyc, 1, 0);
      drain("hold");

      // Reset in the middle of RUN (iteration 5) abandons the operation
      send(vt[2], 1'b0, acc);
      repeat (5) @(negedge clk);
      check_int("abort_busy_before", int'(busy), 1, 0);
      rst_n = 1'b0;
      #1;
      check_int("abort_busy_drop", int'(busy), 0, 0);
      check_int("abort_in_ready", int'(in_ready), 0, 0);
      check_int("abort_out_valid", int'(out_valid), 0, 0);
      check_int("abort_x_out", int'(x_out), 0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_int("abort_in_ready_rise", int'(in_ready), 1, 0);
      ov_seen = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (out_valid) ov_seen++;
      end
      check_int("abort_no_result", ov_seen, 0, 0);
      send(vt[2], 1'b1, acc);
      drain("after_abort");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
